// File: rtl/operand_fetch16.sv
// Operand-fetch stage ahead of the 16-bit logic unit.
// Register file read with write-first bypass into a 2-entry output FIFO.
module operand_fetch16 #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    req_addr_a,
    input  logic [AW-1:0]    req_addr_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [15:0]      req_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] rd_a, rd_b;
    logic [WIDTH-1:0] head_a, head_b;
    logic [WIDTH-1:0] tail_a, tail_b;
    logic push, pop;
    logic ld_head_new, ld_head_tail, ld_tail_new;

    assign req_ready = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = req_valid & req_ready;
    assign pop       = out_valid & out_ready;
    assign out_a     = head_a;
    assign out_b     = head_b;

    // Read ports with write-first bypass of same-cycle writes
    always_comb begin
        rd_a = regs[req_addr_a];
        rd_b = regs[req_addr_b];
        if (wr_en && (wr_addr == req_addr_a)) rd_a = wr_data;
        if (wr_en && (wr_addr == req_addr_b)) rd_b = wr_data;
    end

    // Register file storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Buffer occupancy state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    // Next occupancy and slot load selects
    always_comb begin
        state_nxt    = state;
        ld_head_new  = 1'b0;
        ld_head_tail = 1'b0;
        ld_tail_new  = 1'b0;
        unique case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt   = ONE;
                    ld_head_new = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    ld_head_new = 1'b1;
                end else if (push) begin
                    state_nxt   = FULL;
                    ld_tail_new = 1'b1;
                end else if (pop) begin
                    state_nxt   = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt    = ONE;
                    ld_head_tail = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Head/tail slots; head keeps last popped value when empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_a <= '0;
            head_b <= '0;
            tail_a <= '0;
            tail_b <= '0;
        end else begin
            if (ld_head_new) begin
                head_a <= rd_a;
                head_b <= rd_b;
            end else if (ld_head_tail) begin
                head_a <= tail_a;
                head_b <= tail_b;
            end
            if (ld_tail_new) begin
                tail_a <= rd_a;
                tail_b <= rd_b;
            end
        end
    end

    // Wrapping count of accepted requests
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     req_count <= 16'h0000;
        else if (push) req_count <= req_count + 16'h0001;
    end

endmodule

// File: tb/tb_operand_fetch16.sv
// Bench for operand_fetch16.
// Scoreboard queue filled on accept, drained by a monitor on pops.
module tb_operand_fetch16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_addr_a = '0;
    logic [2:0]  req_addr_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [15:0] req_count;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] sb [$];
    logic [15:0] mdl [8];

    operand_fetch16 dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr_a (req_addr_a),
        .req_addr_b (req_addr_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .req_count  (req_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout expected progress", nm);
    endtask

    // Monitor: compare head against scoreboard on every pop
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: got %h%h expected none",
                         out_a, out_b);
            end else begin
                check("sb_ab", {out_a, out_b}, sb.pop_front());
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
        mdl[a] = d;
    endtask

    task automatic req1(input logic [2:0] a, input logic [2:0] b,
                        input logic [15:0] ea, input logic [15:0] eb);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1;
        req_addr_a = a;
        req_addr_b = b;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (req_ready) begin
                sb.push_back({ea, eb});
                ok = 1'b1;
            end
        end
        if (!ok) fail("req_timeout");
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int t = 0; t < 50 && sb.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) fail(nm);
        @(posedge clk);
        #1 check({nm, "_empty"}, out_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 1'b1);
        check("rst_valid", out_valid, 1'b0);
        check("rst_a", out_a, 16'h0000);
        check("rst_b", out_b, 16'h0000);
        check("rst_cnt", req_count, 16'h0000);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // basic fetch
        wr(3'd3, 16'hF0F0);
        wr(3'd4, 16'h00FF);
        req1(3'd3, 3'd4, 16'hF0F0, 16'h00FF);
        check("t2_valid", out_valid, 1'b1);
        check("t2_a", out_a, 16'hF0F0);
        check("t2_b", out_b, 16'h00FF);
        check("t2_cnt", req_count, 16'd1);
        drain("t2_drain");

        // write-first bypass
        wr(3'd2, 16'h5555);
        wr_en = 1'b1;
        wr_addr = 3'd2;
        wr_data = 16'h1234;
        req_valid = 1'b1;
        req_addr_a = 3'd2;
        req_addr_b = 3'd2;
        @(negedge clk);
        check("t3_ready", req_ready, 1'b1);
        sb.push_back({16'h1234, 16'h1234});
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        req_valid = 1'b0;
        mdl[2] = 16'h1234;
        check("t3_a", out_a, 16'h1234);
        check("t3_b", out_b, 16'h1234);
        drain("t3_drain");
        check("t3_cnt", req_count, 16'd2);

        // backpressure
        out_ready = 1'b0;
        req_valid = 1'b1;
        req_addr_a = 3'd3;
        req_addr_b = 3'd4;
        @(negedge clk);
        check("t4_rdy1", req_ready, 1'b1);
        sb.push_back({16'hF0F0, 16'h00FF});
        @(posedge clk);
        #1;
        req_addr_a = 3'd4;
        req_addr_b = 3'd3;
        @(negedge clk);
        check("t4_rdy2", req_ready, 1'b1);
        sb.push_back({16'h00FF, 16'hF0F0});
        @(posedge clk);
        #1;
        req_addr_a = 3'd2;
        req_addr_b = 3'd2;
        @(negedge clk);
        check("t4_rdy3", req_ready, 1'b0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("t4_valid", out_valid, 1'b1);
        check("t4_head", {out_a, out_b}, {16'hF0F0, 16'h00FF});
        wr(3'd3, 16'hAAAA);
        repeat (2) @(posedge clk);
        #1;
        check("t4_snap", {out_a, out_b}, {16'hF0F0, 16'h00FF});
        check("t4_full", req_ready, 1'b0);
        out_ready = 1'b1;
        drain("t4_drain");
        check("t4_cnt", req_count, 16'd4);

        // streaming push+pop in ONE state (one priming push)
        for (int i = 0; i < 8; i++) wr(i[2:0], 16'h1111 * 16'(i + 1));
        out_ready = 1'b0;
        req1(3'd0, 3'd7, mdl[0], mdl[7]);
        out_ready = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_addr_a = i[2:0];
            req_addr_b = 3'(i + 3);
            @(negedge clk);
            check("t5_valid", out_valid, 1'b1);
            check("t5_ready", req_ready, 1'b1);
            sb.push_back({mdl[i[2:0]], mdl[3'(i + 3)]});
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        drain("t5_drain");
        check("t5_cnt", req_count, 16'd15);

        // reset in the middle of traffic
        out_ready = 1'b0;
        req1(3'd1, 3'd2, mdl[1], mdl[2]);
        req1(3'd3, 3'd4, mdl[3], mdl[4]);
        #3 reset = 1'b1;
        sb.delete();
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        #1;
        check("mrst_ready", req_ready, 1'b1);
        check("mrst_valid", out_valid, 1'b0);
        check("mrst_a", out_a, 16'h0000);
        check("mrst_b", out_b, 16'h0000);
        check("mrst_cnt", req_count, 16'h0000);
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        req1(3'd5, 3'd5, 16'h0000, 16'h0000);
        check("mrst_r5", {out_a, out_b}, 32'h0);
        drain("mrst_drain");
        check("mrst_cnt1", req_count, 16'd1);

        // counter wrap
        wr(3'd1, 16'h0F0F);
        wr(3'd6, 16'h6666);
        req_valid = 1'b1;
        req_addr_a = 3'd1;
        req_addr_b = 3'd6;
        n = 0;
        for (int c = 0; c < 70000 && n < 65534; c++) begin
            @(negedge clk);
            if (req_ready) begin
                sb.push_back({16'h0F0F, 16'h6666});
                n++;
            end
        end
        if (n < 65534) fail("wrap_timeout");
        @(posedge clk);
        #1 req_valid = 1'b0;
        drain("wrap_drain");
        check("wrap_ffff", req_count, 16'hFFFF);
        req1(3'd6, 3'd1, 16'h6666, 16'h0F0F);
        check("wrap_zero", req_count, 16'h0000);
        drain("wrap_drain2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
